// File: rtl/sblock_cfg_pkg.sv
// Shared constants and FSM state type for the switch-block configuration loader.
package sblock_cfg_pkg;

  localparam int SBLK_BITS_W = 18;
  localparam int SBLK_DOTS   = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    DONE
  } cfg_state_t;

endpackage

// File: rtl/sblock_cfg_deser.sv
// Beat deserializer: shifts DATA_W-wide beats MSB-first into an 18-bit frame.
// `frame` already includes the beat being accepted, so it is valid alongside `frame_done`.
module sblock_cfg_deser
  import sblock_cfg_pkg::*;
#(
  parameter int DATA_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   beat_valid,
  input  logic [DATA_W-1:0]      beat,
  output logic [SBLK_BITS_W-1:0] frame,
  output logic                   frame_done
);

  localparam int BEATS = SBLK_BITS_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [SBLK_BITS_W-1:0] shift_q;
  logic [CNT_W-1:0]       cnt_q;

  always_comb begin
    frame      = (shift_q << DATA_W) | SBLK_BITS_W'(beat);
    frame_done = beat_valid && (cnt_q == CNT_W'(BEATS - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (beat_valid) begin
      shift_q <= frame;
      cnt_q   <= frame_done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sblock_cfg_loader.sv
// Switch-block configuration loader: packs a beat stream into frames and strobes
// them into blocks 0..NUM_BLOCKS-1. Define SBLK_CFG_CHECKSUM_EN for the XOR checksum beat.
module sblock_cfg_loader
  import sblock_cfg_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int DATA_W     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_W-1:0]      cfg_data,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  output logic [SBLK_BITS_W-1:0] bits,
  output logic [NUM_BLOCKS-1:0]  wr_en,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  cfg_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [SBLK_DOTS-1:0]   h_dots_q, v_dots_q;
  logic                   done_q;
  logic                   accept, load_beat, start_pass, frame_done;
  logic [SBLK_BITS_W-1:0] frame;

  // Handshake and strobes decode only the state register, never cfg_valid.
  assign cfg_ready  = (state_q == LOAD) || (state_q == CHECK);
  assign busy       = state_q inside {LOAD, WRITE, CHECK};
  assign wr_en      = (state_q == WRITE) ? (NUM_BLOCKS'(1) << idx_q) : '0;
  assign accept     = cfg_valid && cfg_ready;
  assign load_beat  = accept && (state_q == LOAD);
  assign start_pass = start && ((state_q == IDLE) || (state_q == DONE));
  assign bits       = {h_dots_q, v_dots_q};
  assign done       = done_q;

  sblock_cfg_deser #(.DATA_W(DATA_W)) u_deser (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_pass),
    .beat_valid (load_beat),
    .beat       (cfg_data),
    .frame      (frame),
    .frame_done (frame_done)
  );

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD:       if (frame_done) state_d = WRITE;
      WRITE: begin
        if (idx_q == LAST_IDX) begin
`ifdef SBLK_CFG_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = LOAD;
        end
      end
      CHECK:      if (accept) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      h_dots_q <= '0;
      v_dots_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_pass) begin
        idx_q  <= '0;
        done_q <= 1'b0;
      end else begin
        if (state_q == WRITE && idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        if (state_d == DONE && state_q != DONE) done_q <= 1'b1;
      end
      // The shared bus changes only on frame completion so blocks see a stable value.
      if (frame_done) {h_dots_q, v_dots_q} <= frame;
    end
  end

`ifdef SBLK_CFG_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (rst || start_pass) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else if (load_beat) begin
      acc_q <= acc_q ^ cfg_data;
    end else if (accept && state_q == CHECK) begin
      err_q <= (acc_q ^ cfg_data) != '0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Self-checking bench for sblock_cfg_loader; frame vectors from a table, strobes
// checked by a scoreboard. Works with or without SBLK_CFG_CHECKSUM_EN.
module tb_sblock_cfg_loader;

  localparam int NB = 4;
  localparam int DW = 6;
`ifdef SBLK_CFG_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, cfg_valid, cfg_ready, busy, done, err;
  logic [DW-1:0] cfg_data;
  logic [17:0]   bits;
  logic [NB-1:0] wr_en;

  sblock_cfg_loader #(.NUM_BLOCKS(NB), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .bits      (bits),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0]  b0, b1, b2;
    logic [17:0] exp_bits;
  } vec_t;

  typedef struct {
    logic [3:0]  wr_en;
    logic [17:0] bits;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] beat_of(input vec_t v, input int k);
    case (k)
      0:       return v.b0;
      1:       return v.b1;
      default: return v.b2;
    endcase
  endfunction

  // Every strobe must match the next expected frame; ready must be low while strobing.
  always @(negedge clk) begin
    if (!rst && wr_en != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_wr_en", {28'd0, wr_en}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_en", {28'd0, wr_en}, {28'd0, mon_e.wr_en});
        check("bits", {14'd0, bits}, {14'd0, mon_e.bits});
        check("ready_in_write", {31'd0, cfg_ready}, 32'd0);
      end
    end
  end

  task automatic send_beat(input logic [5:0] d, input int gap);
    logic took;
    repeat (gap) begin
      cfg_valid = 1'b0;
      step();
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    for (int n = 0; ; n++) begin
      took = cfg_ready;
      step();
      if (took) break;
      if (n > 20) begin
        check("beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic run_pass(input int base, input int gap, input bit bad, input bit poke,
                          input bit check_len);
    logic [5:0] acc;
    logic [5:0] d;
    int         c0;
    acc       = '0;
    cfg_valid = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    c0    = cyc;
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_err", {31'd0, err}, 32'd0);
    check("busy_load", {31'd0, busy}, 32'd1);
    for (int blk = 0; blk < NB; blk++) begin
      sb.push_back('{wr_en: 4'(1 << blk), bits: vecs[base + blk].exp_bits});
      for (int k = 0; k < 3; k++) begin
        d   = beat_of(vecs[base + blk], k);
        acc = acc ^ d;
        send_beat(d, gap);
      end
      if (poke && blk == 1) begin
        check("busy_poke", {31'd0, busy}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    if (CK_EN) send_beat(acc ^ {5'd0, bad}, gap);
    cfg_valid = 1'b0;
    for (int n = 0; n < 50 && !done; n++) step();
    check("done", {31'd0, done}, 32'd1);
    if (check_len) check("pass_len", cyc - c0, 16 + int'(CK_EN));
    check("err", {31'd0, err}, {31'd0, CK_EN & bad});
    check("busy_end", {31'd0, busy}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);
    cfg_valid = 1'b1;
    step();
    step();
    check("ready_in_done", {31'd0, cfg_ready}, 32'd0);
    check("done_hold", {31'd0, done}, 32'd1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{6'h3F, 6'h00, 6'h15, 18'h3F015};
    vecs[1]  = '{6'h01, 6'h02, 6'h03, 18'h01083};
    vecs[2]  = '{6'h2A, 6'h15, 6'h3F, 18'h2A57F};
    vecs[3]  = '{6'h00, 6'h3F, 6'h00, 18'h00FC0};
    vecs[4]  = '{6'h12, 6'h34, 6'h05, 18'h12D05};
    vecs[5]  = '{6'h3F, 6'h3F, 6'h3F, 18'h3FFFF};
    vecs[6]  = '{6'h00, 6'h00, 6'h01, 18'h00001};
    vecs[7]  = '{6'h20, 6'h01, 6'h10, 18'h20050};
    vecs[8]  = '{6'h05, 6'h0A, 6'h14, 18'h05294};
    vecs[9]  = '{6'h11, 6'h22, 6'h33, 18'h118B3};
    vecs[10] = '{6'h1F, 6'h2E, 6'h3D, 18'h1FBBD};
    vecs[11] = '{6'h08, 6'h10, 6'h20, 18'h08420};

    rst       = 1'b1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    repeat (3) step();
    check("rst_bits", {14'd0, bits}, 32'd0);
    check("rst_wr_en", {28'd0, wr_en}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst       = 1'b0;
    cfg_valid = 1'b1;
    step();
    step();
    check("idle_ready", {31'd0, cfg_ready}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    cfg_valid = 1'b0;

    // basic, backpressure, bad checksum, back-to-back good pass, start while busy
    run_pass(0, 0, 1'b0, 1'b0, 1'b1);
    run_pass(4, 1, 1'b0, 1'b0, 1'b0);
    run_pass(8, 0, 1'b1, 1'b0, 1'b1);
    run_pass(0, 0, 1'b0, 1'b0, 1'b1);
    run_pass(4, 0, 1'b0, 1'b1, 1'b0);

    // Reset during beat 2 of block 2, after blocks 0 and 1 are written.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int blk = 0; blk < 2; blk++) begin
      sb.push_back('{wr_en: 4'(1 << blk), bits: vecs[8 + blk].exp_bits});
      for (int k = 0; k < 3; k++) send_beat(beat_of(vecs[8 + blk], k), 0);
    end
    send_beat(vecs[10].b0, 0);
    send_beat(vecs[10].b1, 0);
    cfg_valid = 1'b1;
    cfg_data  = vecs[10].b2;
    check("ready_before_rst", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    cfg_valid = 1'b0;
    check("mid_rst_bits", {14'd0, bits}, 32'd0);
    check("mid_rst_wr_en", {28'd0, wr_en}, 32'd0);
    check("mid_rst_ready", {31'd0, cfg_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_written", sb.size(), 32'd0);
    step();
    check("mid_rst_idle", {31'd0, busy}, 32'd0);

    run_pass(8, 0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
